// File: rtl/home_auto_pkg.sv
// rtl/home_auto_pkg.sv - shared types and constants for the home alert scheduler
// Holds the scheduler state enum, source indices, display codes and default
// temperature thresholds. No ports.
package home_auto_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int NUM_SRC = 5;

    localparam logic [2:0] SRC_FRONT  = 3'd0;
    localparam logic [2:0] SRC_REAR   = 3'd1;
    localparam logic [2:0] SRC_FIRE   = 3'd2;
    localparam logic [2:0] SRC_WINDOW = 3'd3;
    localparam logic [2:0] SRC_TEMP   = 3'd4;

    localparam logic [2:0] DISP_IDLE   = 3'd0;
    localparam logic [2:0] DISP_FRONT  = 3'd1;
    localparam logic [2:0] DISP_REAR   = 3'd2;
    localparam logic [2:0] DISP_FIRE   = 3'd3;
    localparam logic [2:0] DISP_WINDOW = 3'd4;
    localparam logic [2:0] DISP_TEMP   = 3'd5;

    localparam logic [7:0] T_HIGH_DEF = 8'd70;
    localparam logic [7:0] T_LOW_DEF  = 8'd50;

    // Display codes are the source index offset by one so that 0 means idle.
    function automatic logic [2:0] disp_code(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// rtl/rr_pick5.sv - combinational five-way round-robin picker
// Ports:
//   pending[4:0] in  outstanding requests
//   ptr[2:0]     in  index of the last completed grant (0..4)
//   valid        out some request is pending
//   idx[2:0]     out first pending index searching ptr+1 .. ptr+5 mod 5
module rr_pick5
    import home_auto_pkg::*;
(
    input  logic [4:0] pending,
    input  logic [2:0] ptr,
    output logic       valid,
    output logic [2:0] idx
);

    logic [3:0] pos;

    // Walk the search order backwards so the nearest candidate is written last.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        pos   = 4'd0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'(NUM_SRC)) begin
                pos = pos - 4'(NUM_SRC);
            end
            if (pending[pos[2:0]]) begin
                valid = 1'b1;
                idx   = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/home_alert_scheduler.sv
// rtl/home_alert_scheduler.sv - round-robin annunciator scheduler for five home sensors
// Ports:
//   clk, Rst             clock and asynchronous active-low reset
//   SFD, SRD, SFA, SW    door/fire/window sensor requests
//   ST[7:0]              temperature reading
//   ack                  operator acknowledge, ends the current grant
//   grant[4:0]           one-hot serviced source
//   display[2:0]         code of the granted source (0 idle)
//   cooler, heater       temperature drive while temp is granted
//   pending[4:0]         latched outstanding requests
module home_alert_scheduler
    import home_auto_pkg::*;
#(
    parameter int         DWELL  = 4,
    parameter logic [7:0] T_HIGH = T_HIGH_DEF,
    parameter logic [7:0] T_LOW  = T_LOW_DEF
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       SFD,
    input  logic       SRD,
    input  logic       SFA,
    input  logic       SW,
    input  logic [7:0] ST,
    input  logic       ack,
    output logic [4:0] grant,
    output logic [2:0] display,
    output logic       cooler,
    output logic       heater,
    output logic [4:0] pending
);

    localparam int CW = $clog2(DWELL + 1);

    state_e        state_q, state_d;
    logic [4:0]    pending_q, pending_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    cur_q, cur_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cool_q, cool_d;
    logic [4:0]    grant_q, grant_d;
    logic [2:0]    display_q, display_d;
    logic          cooler_q, cooler_d;
    logic          heater_q, heater_d;

    logic [4:0] req;
    logic [4:0] clr;
    logic       enter;
    logic [2:0] enter_idx;
    logic       pick_valid;
    logic [2:0] pick_idx;
    logic       dwell_done;

    rr_pick5 u_pick (
        .pending (pending_q),
        .ptr     (ptr_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    assign dwell_done = (cnt_q == CW'(DWELL - 1));

    always_comb begin
        req       = {(ST > T_HIGH) | (ST < T_LOW), SW, SFA, SRD, SFD};
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        cool_d    = cool_q;
        clr       = 5'd0;
        enter     = 1'b0;
        enter_idx = cur_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    enter     = 1'b1;
                    enter_idx = pick_idx;
                end
            end
            GRANT: begin
                // Fire preempts any other grant straight away; the preempted
                // source keeps its pending bit and the pointer stays put.
                if (cur_q != SRC_FIRE && pending_q[SRC_FIRE]) begin
                    enter     = 1'b1;
                    enter_idx = SRC_FIRE;
                end else if (ack || (cur_q != SRC_FIRE && dwell_done)) begin
                    state_d = GAP;
                    clr     = 5'(1) << cur_q;
                    ptr_d   = cur_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter) begin
            state_d = GRANT;
            cur_d   = enter_idx;
            cnt_d   = '0;
            cool_d  = (ST > T_HIGH);
        end

        // A request in the completion cycle re-arms the bit (set wins).
        pending_d = (pending_q & ~clr) | req;

        grant_d   = 5'd0;
        display_d = DISP_IDLE;
        cooler_d  = 1'b0;
        heater_d  = 1'b0;
        if (state_d == GRANT) begin
            grant_d   = 5'(1) << cur_d;
            display_d = disp_code(cur_d);
            cooler_d  = (cur_d == SRC_TEMP) && cool_d;
            heater_d  = (cur_d == SRC_TEMP) && !cool_d;
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            pending_q <= 5'd0;
            ptr_q     <= SRC_TEMP;
            cur_q     <= SRC_FRONT;
            cnt_q     <= '0;
            cool_q    <= 1'b0;
            grant_q   <= 5'd0;
            display_q <= DISP_IDLE;
            cooler_q  <= 1'b0;
            heater_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            cool_q    <= cool_d;
            grant_q   <= grant_d;
            display_q <= display_d;
            cooler_q  <= cooler_d;
            heater_q  <= heater_d;
        end
    end

    assign grant   = grant_q;
    assign display = display_q;
    assign cooler  = cooler_q;
    assign heater  = heater_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_home_alert_scheduler.sv
// tb/tb_home_alert_scheduler.sv - directed self-checking bench for home_alert_scheduler
module tb_home_alert_scheduler;

    logic       clk = 1'b0;
    logic       Rst;
    logic       SFD, SRD, SFA, SW, ack;
    logic [7:0] ST;
    logic [4:0] grant;
    logic [2:0] display;
    logic       cooler, heater;
    logic [4:0] pending;

    int tests  = 0;
    int failed = 0;

    home_alert_scheduler #(.DWELL(4)) dut (
        .clk     (clk),
        .Rst     (Rst),
        .SFD     (SFD),
        .SRD     (SRD),
        .SFA     (SFA),
        .SW      (SW),
        .ST      (ST),
        .ack     (ack),
        .grant   (grant),
        .display (display),
        .cooler  (cooler),
        .heater  (heater),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [4:0] g, input logic [2:0] d,
                             input logic c, input logic h);
        check({tag, ".grant"}, 8'(grant), 8'(g));
        check({tag, ".display"}, 8'(display), 8'(d));
        check({tag, ".cooler"}, 8'(cooler), 8'(c));
        check({tag, ".heater"}, 8'(heater), 8'(h));
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        check_out("rst", 5'd0, 3'd0, 1'b0, 1'b0);
        check("rst.pending", 8'(pending), 8'h00);
    endtask

    logic [4:0] rr_exp [4];

    initial begin
        Rst = 1'b0; SFD = 1'b0; SRD = 1'b0; SFA = 1'b0; SW = 1'b0; ack = 1'b0;
        ST  = 8'd60;
        rr_exp[0] = 5'b00001; rr_exp[1] = 5'b00010; rr_exp[2] = 5'b01000; rr_exp[3] = 5'b00001;

        // Reset state
        #3;
        check_out("reset", 5'd0, 3'd0, 1'b0, 1'b0);
        check("reset.pending", 8'(pending), 8'h00);
        tick();
        Rst = 1'b1;
        tick();
        check("idle.grant", 8'(grant), 8'h00);

        // Single SFD pulse: pending next edge, grant the edge after, 4 cycles
        SFD = 1'b1;
        tick();
        check("t1.pending", 8'(pending), 8'h01);
        check("t1.grant0", 8'(grant), 8'h00);
        SFD = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            check_out("t1.front", 5'b00001, 3'd1, 1'b0, 1'b0);
            tick();
        end
        check_out("t1.gap", 5'd0, 3'd0, 1'b0, 1'b0);
        check("t1.pend_clr", 8'(pending), 8'h00);
        tick();
        check("t1.idle", 8'(grant), 8'h00);

        // Three held requests rotate front, rear, window, front
        do_reset();
        SFD = 1'b1; SRD = 1'b1; SW = 1'b1;
        tick();
        check("t2.pending", 8'(pending), 8'h0B);
        tick();
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 4; c++) begin
                check("t2.rr", 8'(grant), 8'(rr_exp[g]));
                tick();
            end
            check("t2.gap", 8'(grant), 8'h00);
            tick();
            check("t2.idle", 8'(grant), 8'h00);
            tick();
        end
        SFD = 1'b0; SRD = 1'b0; SW = 1'b0;

        // Fire preempts rear in its second cycle, holds until ack, rear resumes
        do_reset();
        SRD = 1'b1;
        tick();
        SRD = 1'b0;
        tick();
        check_out("t3.rear", 5'b00010, 3'd2, 1'b0, 1'b0);
        tick();
        SFA = 1'b1;
        tick();
        SFA = 1'b0;
        check("t3.rear2", 8'(grant), 8'h02);
        check("t3.pend_f", 8'(pending), 8'h06);
        tick();
        check_out("t3.fire", 5'b00100, 3'd3, 1'b0, 1'b0);
        check("t3.pend_keep", 8'(pending), 8'h06);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("t3.fire_hold", 8'(grant), 8'h04);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t3.gap", 8'(grant), 8'h00);
        check("t3.pend_r", 8'(pending), 8'h02);
        tick();
        check("t3.idle", 8'(grant), 8'h00);
        tick();
        check_out("t3.rear_again", 5'b00010, 3'd2, 1'b0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t3.pend_done", 8'(pending), 8'h00);
        tick();

        // Temperature: cooling at 80, heating at 40, direction latched
        ST = 8'd80;
        tick();
        check("t4.pending", 8'(pending), 8'h10);
        tick();
        check_out("t4.cool", 5'b10000, 3'd5, 1'b1, 1'b0);
        ST = 8'd40; ack = 1'b1;
        tick();
        ack = 1'b0;
        check_out("t4.gap", 5'd0, 3'd0, 1'b0, 1'b0);
        check("t4.pend_set_wins", 8'(pending), 8'h10);
        tick();
        tick();
        check_out("t4.heat", 5'b10000, 3'd5, 1'b0, 1'b1);
        ST = 8'd80;
        tick();
        check_out("t4.latched", 5'b10000, 3'd5, 1'b0, 1'b1);
        ST = 8'd60; ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t4.pend_clr", 8'(pending), 8'h00);
        tick();

        // Window acked in its first cycle; ack while idle is ignored
        SW = 1'b1;
        tick();
        SW = 1'b0;
        tick();
        check_out("t5.window", 5'b01000, 3'd4, 1'b0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t5.gap", 8'(grant), 8'h00);
        check("t5.pend_clr", 8'(pending), 8'h00);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_out("t5.idle_ack", 5'd0, 3'd0, 1'b0, 1'b0);
        check("t5.idle_pend", 8'(pending), 8'h00);
        tick();
        check("t5.idle2", 8'(grant), 8'h00);

        // Threshold boundaries: 70 and 50 do not request, 71 does
        ST = 8'd70;
        tick();
        check("t6.st70", 8'(pending), 8'h00);
        ST = 8'd50;
        tick();
        check("t6.st50", 8'(pending), 8'h00);
        ST = 8'd71;
        tick();
        check("t6.st71", 8'(pending), 8'h10);
        tick();
        check_out("t6.cool71", 5'b10000, 3'd5, 1'b1, 1'b0);
        ST = 8'd60; ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();

        // Asynchronous reset mid-grant, then front re-granted after release
        SFD = 1'b1;
        tick();
        tick();
        check("t7.front", 8'(grant), 8'h01);
        #2;
        Rst = 1'b0;
        #1;
        check_out("t7.async", 5'd0, 3'd0, 1'b0, 1'b0);
        check("t7.pend", 8'(pending), 8'h00);
        tick();
        check("t7.held", 8'(grant), 8'h00);
        #2;
        Rst = 1'b1;
        tick();
        check("t7.rel_pend", 8'(pending), 8'h01);
        check("t7.rel_grant", 8'(grant), 8'h00);
        tick();
        check_out("t7.regrant", 5'b00001, 3'd1, 1'b0, 1'b0);
        SFD = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
